// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Decoupled instruction-fetch front end. Owns the fetch PC, issues
//            in-order requests to a variable-latency instruction memory,
//            buffers returned instructions in a DEPTH-entry queue and hands
//            {pc, inst} to decode over valid/ready. A redirect flushes the
//            queue and arranges for stale in-flight responses to be dropped.
// Ports    : clk, rst                      - clock, sync active-high reset
//            req_valid/req_ready/req_addr  - fetch request to memory
//            resp_valid/resp_data          - in-order memory response
//            redirect_valid/redirect_pc    - flush and restart fetch
//            out_valid/out_ready/out_pc/out_inst - head entry to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst
);

    localparam int unsigned     PW          = $clog2(DEPTH);
    localparam logic [PW:0]     c_one       = (PW+1)'(1);
    localparam logic [PW:0]     c_zero      = '0;
    localparam logic [PW+1:0]   c_depth     = (PW+2)'(DEPTH);
    localparam logic [XLEN-1:0] c_instBytes = XLEN'(4);
    localparam logic [XLEN-1:0] c_alignMask = XLEN'(3);

    logic [XLEN-1:0]  r_fetchPc;
    logic [XLEN-1:0]  r_entryPc   [DEPTH];
    logic [ILEN-1:0]  r_entryInst [DEPTH];
    logic [DEPTH-1:0] r_filled;
    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PW:0]      r_head;
    logic [PW:0]      r_fill;
    logic [PW:0]      r_tail;
    logic [PW:0]      r_alloc;
    logic [PW:0]      r_dropCnt;

    logic [PW-1:0]    w_headIdx;
    logic [PW-1:0]    w_fillIdx;
    logic [PW-1:0]    w_tailIdx;
    logic [PW:0]      w_unfilled;
    logic [PW+1:0]    w_credits;
    logic             w_issue;
    logic             w_deq;
    logic             w_store;
    logic             w_drop;

    always_comb begin
        w_headIdx  = r_head[PW-1:0];
        w_fillIdx  = r_fill[PW-1:0];
        w_tailIdx  = r_tail[PW-1:0];
        // Requests issued for the current epoch whose data has not arrived.
        w_unfilled = r_tail - r_fill;
        // Every queue slot or pending drop consumes one in-flight credit.
        w_credits  = {1'b0, r_alloc} + {1'b0, r_dropCnt};

        req_valid  = !rst && !redirect_valid && (w_credits < c_depth);
        req_addr   = r_fetchPc;
        out_valid  = !rst && !redirect_valid && r_filled[w_headIdx];
        out_pc     = r_entryPc[w_headIdx];
        out_inst   = r_entryInst[w_headIdx];

        w_issue    = req_valid && req_ready;
        w_deq      = out_valid && out_ready;
        w_drop     = resp_valid && (r_dropCnt != c_zero);
        w_store    = resp_valid && (r_dropCnt == c_zero) && !redirect_valid;
    end

    // Control state: fetch PC, pointers, occupancy and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
            r_filled  <= '0;
            r_head    <= c_zero;
            r_fill    <= c_zero;
            r_tail    <= c_zero;
            r_alloc   <= c_zero;
            r_dropCnt <= c_zero;
        end else if (redirect_valid) begin
            r_fetchPc <= redirect_pc & ~c_alignMask;
            r_filled  <= '0;
            r_head    <= c_zero;
            r_fill    <= c_zero;
            r_tail    <= c_zero;
            r_alloc   <= c_zero;
            // Everything still owed by memory becomes a drop, less the one
            // response consumed this very cycle.
            r_dropCnt <= r_dropCnt + w_unfilled - (resp_valid ? c_one : c_zero);
        end else begin
            if (w_issue) begin
                r_fetchPc           <= r_fetchPc + c_instBytes;
                r_tail              <= r_tail + c_one;
                r_filled[w_tailIdx] <= 1'b0;
            end
            if (w_store) begin
                r_filled[w_fillIdx] <= 1'b1;
                r_fill              <= r_fill + c_one;
            end
            if (w_drop) begin
                r_dropCnt <= r_dropCnt - c_one;
            end
            if (w_deq) begin
                r_filled[w_headIdx] <= 1'b0;
                r_head              <= r_head + c_one;
            end
            case ({w_issue, w_deq})
                2'b10:   r_alloc <= r_alloc + c_one;
                2'b01:   r_alloc <= r_alloc - c_one;
                default: r_alloc <= r_alloc;
            endcase
        end
    end

    // Payload storage needs no reset; the filled bits qualify it.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_entryPc[w_tailIdx] <= r_fetchPc;
        end
        if (w_store) begin
            r_entryInst[w_fillIdx] <= resp_data;
        end
    end

endmodule
`default_nettype wire
